// File: rtl/l2_fwd_stall_ctrl.sv
// rtl/l2_fwd_stall_ctrl.sv - L2 forward stall/replay controller and set-conflict flag
// Optional macro L2_FWD_STALL_STATS_EN adds stall_events / max_stall_cycles counters.
module l2_fwd_stall_ctrl #(
  parameter int N_REQS         = 4,
  parameter int REQS_BITS      = 2,
  parameter int LINE_ADDR_BITS = 28,
  parameter int MSG_BITS       = 3,
  parameter int REQ_ID_BITS    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fwd_in_valid,
  output logic                      fwd_in_ready,
  input  logic [MSG_BITS-1:0]       fwd_in_coh_msg,
  input  logic [LINE_ADDR_BITS-1:0] fwd_in_addr,
  input  logic [REQ_ID_BITS-1:0]    fwd_in_req_id,
  input  logic                      set_fwd_stall,
  input  logic                      clr_fwd_stall,
  input  logic                      set_fwd_stall_i,
  input  logic [REQS_BITS-1:0]      fwd_stall_i_wr_data,
  input  logic                      set_set_conflict,
  input  logic                      clr_set_conflict,
  input  logic                      req_done_valid,
  input  logic [REQS_BITS-1:0]      req_done_i,
  output logic                      fwd_stall,
  output logic [REQS_BITS-1:0]      fwd_stall_i,
  output logic                      set_conflict,
  output logic                      replay_valid,
  input  logic                      replay_ready,
  output logic [MSG_BITS-1:0]       replay_coh_msg,
  output logic [LINE_ADDR_BITS-1:0] replay_addr,
  output logic [REQ_ID_BITS-1:0]    replay_req_id
`ifdef L2_FWD_STALL_STATS_EN
  ,
  output logic [15:0]               stall_events,
  output logic [15:0]               max_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL  = 2'd1,
    REPLAY = 2'd2
  } state_t;

  state_t                   state, next_state;
  logic                     capture;
  logic                     stall_set;
  logic                     stall_clr;
  logic [REQS_BITS-1:0]     wake_idx;
  logic                     wake_now;

  // Index written this cycle takes effect for the wake-up compare so a
  // retire arriving together with the stall verdict is never lost.
  assign wake_idx = set_fwd_stall_i ? fwd_stall_i_wr_data : fwd_stall_i;
  assign wake_now = req_done_valid && (req_done_i == wake_idx);

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    stall_set  = 1'b0;
    stall_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_fwd_stall) begin
          stall_clr = 1'b1;
        end else if (fwd_in_valid && set_fwd_stall) begin
          capture    = 1'b1;
          stall_set  = 1'b1;
          next_state = wake_now ? REPLAY : STALL;
        end
      end
      STALL: begin
        if (req_done_valid && (req_done_i == fwd_stall_i))
          next_state = REPLAY;
      end
      REPLAY: begin
        if (replay_ready) begin
          if (set_fwd_stall && !clr_fwd_stall) begin
            next_state = wake_now ? REPLAY : STALL;
          end else begin
            next_state = IDLE;
            stall_clr  = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      fwd_stall      <= 1'b0;
      fwd_stall_i    <= '0;
      set_conflict   <= 1'b0;
      replay_coh_msg <= '0;
      replay_addr    <= '0;
      replay_req_id  <= '0;
    end else begin
      state <= next_state;
      if (stall_set)
        fwd_stall <= 1'b1;
      else if (stall_clr)
        fwd_stall <= 1'b0;
      if (set_fwd_stall_i)
        fwd_stall_i <= fwd_stall_i_wr_data;
      if (set_set_conflict)
        set_conflict <= 1'b1;
      else if (clr_set_conflict)
        set_conflict <= 1'b0;
      if (capture) begin
        replay_coh_msg <= fwd_in_coh_msg;
        replay_addr    <= fwd_in_addr;
        replay_req_id  <= fwd_in_req_id;
      end
    end
  end

  assign fwd_in_ready = (state == IDLE);
  assign replay_valid = (state == REPLAY);

`ifdef L2_FWD_STALL_STATS_EN
  logic [15:0] run_cnt;
  logic [15:0] run_next;
  logic        enter_stall;
  logic        leave_stall;

  assign enter_stall = (next_state == STALL) && (state != STALL);
  assign leave_stall = (state == STALL) && (next_state != STALL);
  // run_next already includes the current STALL cycle.
  assign run_next    = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_events     <= '0;
      max_stall_cycles <= '0;
      run_cnt          <= '0;
    end else begin
      if (enter_stall && (stall_events != 16'hFFFF))
        stall_events <= stall_events + 16'd1;
      if (state == STALL) begin
        if (leave_stall) begin
          run_cnt <= '0;
          if (run_next > max_stall_cycles)
            max_stall_cycles <= run_next;
        end else begin
          run_cnt <= run_next;
        end
      end
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = (N_REQS > 0);

endmodule

// File: tb/tb_l2_fwd_stall_ctrl.sv
// tb/tb_l2_fwd_stall_ctrl.sv - scoreboard bench for l2_fwd_stall_ctrl
module tb_l2_fwd_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fwd_in_valid = 1'b0;
  logic        fwd_in_ready;
  logic [2:0]  fwd_in_coh_msg = '0;
  logic [27:0] fwd_in_addr = '0;
  logic [3:0]  fwd_in_req_id = '0;
  logic        set_fwd_stall = 1'b0;
  logic        clr_fwd_stall = 1'b0;
  logic        set_fwd_stall_i = 1'b0;
  logic [1:0]  fwd_stall_i_wr_data = '0;
  logic        set_set_conflict = 1'b0;
  logic        clr_set_conflict = 1'b0;
  logic        req_done_valid = 1'b0;
  logic [1:0]  req_done_i = '0;
  logic        fwd_stall;
  logic [1:0]  fwd_stall_i;
  logic        set_conflict;
  logic        replay_valid;
  logic        replay_ready = 1'b0;
  logic [2:0]  replay_coh_msg;
  logic [27:0] replay_addr;
  logic [3:0]  replay_req_id;
`ifdef L2_FWD_STALL_STATS_EN
  logic [15:0] stall_events;
  logic [15:0] max_stall_cycles;
`endif

  int tests = 0;
  int fails = 0;
  logic [34:0] exp_q[$];

  l2_fwd_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .fwd_in_valid(fwd_in_valid), .fwd_in_ready(fwd_in_ready),
    .fwd_in_coh_msg(fwd_in_coh_msg), .fwd_in_addr(fwd_in_addr), .fwd_in_req_id(fwd_in_req_id),
    .set_fwd_stall(set_fwd_stall), .clr_fwd_stall(clr_fwd_stall),
    .set_fwd_stall_i(set_fwd_stall_i), .fwd_stall_i_wr_data(fwd_stall_i_wr_data),
    .set_set_conflict(set_set_conflict), .clr_set_conflict(clr_set_conflict),
    .req_done_valid(req_done_valid), .req_done_i(req_done_i),
    .fwd_stall(fwd_stall), .fwd_stall_i(fwd_stall_i), .set_conflict(set_conflict),
    .replay_valid(replay_valid), .replay_ready(replay_ready),
    .replay_coh_msg(replay_coh_msg), .replay_addr(replay_addr), .replay_req_id(replay_req_id)
`ifdef L2_FWD_STALL_STATS_EN
    , .stall_events(stall_events), .max_stall_cycles(max_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Replay monitor: every handshake must match the oldest parked forward.
  always @(negedge clk) begin
    if (!rst && replay_valid && replay_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL replay_unexpected got=%h expected none",
                 {replay_coh_msg, replay_addr, replay_req_id});
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if ({replay_coh_msg, replay_addr, replay_req_id} !== e) begin
          fails++;
          $display("FAIL replay_fields got=%h expected=%h",
                   {replay_coh_msg, replay_addr, replay_req_id}, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    fwd_in_valid = 0; set_fwd_stall = 0; clr_fwd_stall = 0; set_fwd_stall_i = 0;
    set_set_conflict = 0; clr_set_conflict = 0; req_done_valid = 0; replay_ready = 0;
  endtask

  task automatic issue_fwd(input logic [2:0] m, input logic [27:0] a, input logic [3:0] id,
                           input logic [1:0] idx);
    fwd_in_valid = 1; fwd_in_coh_msg = m; fwd_in_addr = a; fwd_in_req_id = id;
    set_fwd_stall = 1; set_fwd_stall_i = 1; fwd_stall_i_wr_data = idx;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(fwd_in_ready), 32'd1);
    chk({tag, "_stall"}, 32'(fwd_stall), 32'd0);
    chk({tag, "_stall_i"}, 32'(fwd_stall_i), 32'd0);
    chk({tag, "_conflict"}, 32'(set_conflict), 32'd0);
    chk({tag, "_rvalid"}, 32'(replay_valid), 32'd0);
    chk({tag, "_fields"}, 32'({replay_coh_msg, replay_req_id}) ^ 32'(replay_addr), 32'd0);
`ifdef L2_FWD_STALL_STATS_EN
    chk({tag, "_events"}, 32'(stall_events), 32'd0);
    chk({tag, "_max"}, 32'(max_stall_cycles), 32'd0);
`endif
  endtask

  initial begin
    #1 rst = 1;
    #1 chk_reset_vals("reset");
    step();
    rst = 0;

    // Basic replay
    issue_fwd(3'd3, 28'h1234567, 4'd5, 2'd2);
    exp_q.push_back({3'd3, 28'h1234567, 4'd5});
    step(); clear_in();
    chk("t1_stall", 32'(fwd_stall), 32'd1);
    chk("t1_stall_i", 32'(fwd_stall_i), 32'd2);
    chk("t1_ready", 32'(fwd_in_ready), 32'd0);
    chk("t1_rvalid0", 32'(replay_valid), 32'd0);
    req_done_valid = 1; req_done_i = 2;
    step(); clear_in();
    chk("t1_rvalid", 32'(replay_valid), 32'd1);
    chk("t1_raddr", 32'(replay_addr), 32'h1234567);
    replay_ready = 1;
    step(); clear_in();
    chk("t1_idle_ready", 32'(fwd_in_ready), 32'd1);
    chk("t1_idle_stall", 32'(fwd_stall), 32'd0);
    chk("t1_idle_rvalid", 32'(replay_valid), 32'd0);

    // clr wins over set in IDLE
    issue_fwd(3'd1, 28'h0000001, 4'd1, 2'd3);
    clr_fwd_stall = 1;
    step(); clear_in();
    chk("clrwin_ready", 32'(fwd_in_ready), 32'd1);
    chk("clrwin_stall", 32'(fwd_stall), 32'd0);

    // Wrong-index retire
    issue_fwd(3'd1, 28'hABCDEF0, 4'd9, 2'd1);
    exp_q.push_back({3'd1, 28'hABCDEF0, 4'd9});
    step(); clear_in();
    for (int i = 0; i < 10; i++) begin
      req_done_valid = 1; req_done_i = 3;
      step(); clear_in();
      chk("t2_rvalid", 32'(replay_valid), 32'd0);
      chk("t2_stall", 32'(fwd_stall), 32'd1);
    end
    req_done_valid = 1; req_done_i = 1;
    step(); clear_in();
    chk("t2_wake", 32'(replay_valid), 32'd1);

    // Back-pressure, then re-stall on index 0
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 32'(replay_valid), 32'd1);
      chk("t3_hold_addr", 32'(replay_addr), 32'hABCDEF0);
      chk("t3_hold_msgid", 32'({replay_coh_msg, replay_req_id}), 32'({3'd1, 4'd9}));
    end
    replay_ready = 1; set_fwd_stall = 1; set_fwd_stall_i = 1; fwd_stall_i_wr_data = 0;
    exp_q.push_back({3'd1, 28'hABCDEF0, 4'd9});
    step(); clear_in();
    chk("t3_restall_rvalid", 32'(replay_valid), 32'd0);
    chk("t3_restall_stall", 32'(fwd_stall), 32'd1);
    chk("t3_restall_idx", 32'(fwd_stall_i), 32'd0);
    chk("t3_restall_ready", 32'(fwd_in_ready), 32'd0);
    chk("t3_restall_addr", 32'(replay_addr), 32'hABCDEF0);
    req_done_valid = 1; req_done_i = 0;
    step(); clear_in();
    chk("t3_wake", 32'(replay_valid), 32'd1);
    replay_ready = 1;
    step(); clear_in();
    chk("t3_idle", 32'(fwd_in_ready), 32'd1);

    // Conflict flag
    set_set_conflict = 1;
    step(); clear_in();
    chk("t4_set", 32'(set_conflict), 32'd1);
    set_set_conflict = 1; clr_set_conflict = 1;
    step(); clear_in();
    chk("t4_both", 32'(set_conflict), 32'd1);
    step();
    chk("t4_hold", 32'(set_conflict), 32'd1);
    clr_set_conflict = 1;
    step(); clear_in();
    chk("t4_clr", 32'(set_conflict), 32'd0);

    // Same-cycle stall and retire
    issue_fwd(3'd6, 28'h0FFFFFF, 4'hF, 2'd1);
    req_done_valid = 1; req_done_i = 1;
    exp_q.push_back({3'd6, 28'h0FFFFFF, 4'hF});
    step(); clear_in();
    chk("t5_rvalid", 32'(replay_valid), 32'd1);
    chk("t5_stall", 32'(fwd_stall), 32'd1);
    chk("t5_idx", 32'(fwd_stall_i), 32'd1);
    replay_ready = 1;
    step(); clear_in();
    chk("t5_idle", 32'(fwd_in_ready), 32'd1);

    // Reset mid-stall
    set_set_conflict = 1;
    issue_fwd(3'd2, 28'h0000005, 4'd3, 2'd2);
    step(); clear_in();
    chk("t6_in_stall", 32'(fwd_stall), 32'd1);
    #2 rst = 1;
    #1 chk_reset_vals("t6_rst");
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      req_done_valid = 1; req_done_i = 2; replay_ready = 1;
      step(); clear_in();
      chk("t6_no_replay", 32'(replay_valid), 32'd0);
      chk("t6_ready", 32'(fwd_in_ready), 32'd1);
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
